gc_cursor_ctrl: RTL and testbench



---
 rtl/gc_cursor_if.sv | 28 ++
 rtl/gc_cursor_ctrl.sv | 132 +++++++++++++
 tb/tb_gc_cursor_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gc_cursor_if.sv
// CPU, motion-source and register-file signals of the cursor controller.
// slave is the controller's view; master is the surrounding system's view.
interface gc_cursor_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_ack;
  logic        mv_valid;
  logic [8:0]  mv_dx;
  logic [8:0]  mv_dy;
  logic        mv_ready;
  logic        rf_we;
  logic [11:0] rf_addr;
  logic [31:0] rf_wd;
  logic [31:0] rf_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, mv_valid, mv_dx, mv_dy, rf_rd,
    output cpu_rd, cpu_ack, mv_ready, rf_we, rf_addr, rf_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, mv_valid, mv_dx, mv_dy, rf_rd,
    input  cpu_rd, cpu_ack, mv_ready, rf_we, rf_addr, rf_wd
  );
endinterface

// File: rtl/gc_cursor_ctrl.sv
// Arbitrates the register-file port between CPU accesses and cursor motion packets.
// Define GC_CURSOR_WRAP_EN to wrap the cursor at the screen edges instead of clamping.
module gc_cursor_ctrl #(
  parameter int unsigned X_MAX  = 639,
  parameter int unsigned Y_MAX  = 479,
  parameter logic [11:0] ADDR_X = 12'h004,
  parameter logic [11:0] ADDR_Y = 12'h008
) (
  input  logic        clk,
  input  logic        rst_n,
  gc_cursor_if.slave  bus_io
);

  localparam int unsigned CW = 11;
  localparam logic signed [12:0] XMAX_S = 13'(X_MAX);
  localparam logic signed [12:0] YMAX_S = 13'(Y_MAX);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_DONE, MV_X, MV_Y} state_e;

  state_e       state_q, state_d;
  logic         prio_mv_q, prio_mv_d;
  logic [8:0]   dx_q, dx_d;
  logic [8:0]   dy_q, dy_d;
  logic [31:0]  cpu_rd_q, cpu_rd_d;
  logic         cpu_ack_q, cpu_ack_d;

  logic         cpu_win_c, mv_win_c, mv_ready_c;
  logic         rf_we_c;
  logic [11:0]  rf_addr_c;
  logic [31:0]  rf_wd_c;
  logic signed [11:0] cur_s, dx_s, dy_s, sum_s;

  // Range limiting of a 12-bit signed coordinate into [0, mx].
  function automatic logic [CW-1:0] lim(input logic signed [11:0] v,
                                        input logic signed [12:0] mx);
    logic signed [12:0] w;
    w = {v[11], v};
`ifdef GC_CURSOR_WRAP_EN
    if (w < 13'sd0)   w = w + mx + 13'sd1;
    else if (w > mx)  w = w - mx - 13'sd1;
`else
    if (w < 13'sd0)   w = 13'sd0;
    else if (w > mx)  w = mx;
`endif
    return w[CW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_mv_q <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      cpu_rd_q  <= '0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_mv_q <= prio_mv_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cpu_rd_q  <= cpu_rd_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  assign cpu_win_c = bus_io.cpu_req  && (!bus_io.mv_valid || !prio_mv_q);
  assign mv_win_c  = bus_io.mv_valid && (!bus_io.cpu_req  ||  prio_mv_q);

  // Current coordinate ignores the upper bits of the stored word.
  assign cur_s = $signed({1'b0, bus_io.rf_rd[CW-1:0]});
  assign dx_s  = $signed({{3{dx_q[8]}}, dx_q});
  assign dy_s  = $signed({{3{dy_q[8]}}, dy_q});
  assign sum_s = (state_q == MV_Y) ? (cur_s - dy_s) : (cur_s + dx_s);

  always_comb begin
    state_d    = state_q;
    prio_mv_d  = prio_mv_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cpu_rd_d   = cpu_rd_q;
    cpu_ack_d  = 1'b0;
    mv_ready_c = 1'b0;
    rf_we_c    = 1'b0;
    rf_addr_c  = '0;
    rf_wd_c    = '0;
    case (state_q)
      IDLE: begin
        if (cpu_win_c) begin
          state_d   = CPU_ACC;
          prio_mv_d = 1'b1;
        end else if (mv_win_c) begin
          mv_ready_c = rst_n;
          dx_d       = bus_io.mv_dx;
          dy_d       = bus_io.mv_dy;
          state_d    = MV_X;
          prio_mv_d  = 1'b0;
        end
      end
      CPU_ACC: begin
        rf_addr_c = bus_io.cpu_addr;
        rf_we_c   = bus_io.cpu_we;
        rf_wd_c   = bus_io.cpu_wd;
        cpu_rd_d  = bus_io.rf_rd;
        cpu_ack_d = 1'b1;
        state_d   = CPU_DONE;
      end
      CPU_DONE: state_d = IDLE;
      // X and Y updates run back to back; IDLE is not revisited in between.
      MV_X: begin
        rf_addr_c = ADDR_X;
        rf_we_c   = 1'b1;
        rf_wd_c   = {21'b0, lim(sum_s, XMAX_S)};
        state_d   = MV_Y;
      end
      MV_Y: begin
        rf_addr_c = ADDR_Y;
        rf_we_c   = 1'b1;
        rf_wd_c   = {21'b0, lim(sum_s, YMAX_S)};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.cpu_rd   = cpu_rd_q;
  assign bus_io.cpu_ack  = cpu_ack_q;
  assign bus_io.mv_ready = mv_ready_c;
  assign bus_io.rf_we    = rf_we_c;
  assign bus_io.rf_addr  = rf_addr_c;
  assign bus_io.rf_wd    = rf_wd_c;

endmodule

// File: tb/tb_gc_cursor_ctrl.sv
// Scoreboard bench for gc_cursor_ctrl: a register-file array model supplies rf_rd,
// a cursor reference model predicts RF writes and CPU read data.
module tb_gc_cursor_ctrl;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam logic [11:0] ADDR_X = 12'h004;
  localparam logic [11:0] ADDR_Y = 12'h008;
  localparam int WX = int'(ADDR_X[3:2]);
  localparam int WY = int'(ADDR_Y[3:2]);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rf_clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  gc_cursor_if bus();

  gc_cursor_ctrl #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y))
    dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External register file: combinational read, synchronous write
  logic [31:0] rf_mem [4];
  assign bus.rf_rd = rf_mem[bus.rf_addr[3:2]];
  always @(posedge clk) begin
    if (rf_clr) for (int i = 0; i < 4; i++) rf_mem[i] <= 32'h0;
    else if (bus.rf_we) rf_mem[bus.rf_addr[3:2]] <= bus.rf_wd;
  end

  typedef struct { bit ack; logic [11:0] addr; logic [31:0] data; bit b2b; } exp_t;
  typedef struct { bit we; logic [11:0] addr; logic [31:0] wd; } cop_t;
  typedef struct { int dx; int dy; } mop_t;

  exp_t exp_q[$];
  cop_t cpu_q[$];
  mop_t mv_q[$];
  logic [31:0] m_rf [4];
  bit   m_prio_mv;
  int   last_wr = -10;

  function automatic int lim(int v, int mx);
`ifdef GC_CURSOR_WRAP_EN
    if (v < 0) return v + mx + 1;
    if (v > mx) return v - mx - 1;
    return v;
`else
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
`endif
  endfunction

  function automatic void push_exp(bit ack, logic [11:0] a, logic [31:0] d, bit b2b);
    exp_t e;
    e.ack = ack; e.addr = a; e.data = d; e.b2b = b2b;
    exp_q.push_back(e);
  endfunction

  function automatic void model_cpu(cop_t op);
    int w;
    w = int'(op.addr[3:2]);
    if (op.we) push_exp(1'b0, op.addr, op.wd, 1'b0);
    push_exp(1'b1, 12'h0, m_rf[w], 1'b0);
    if (op.we) m_rf[w] = op.wd;
    m_prio_mv = 1'b1;
  endfunction

  function automatic void model_mv(mop_t op);
    int nx, ny;
    nx = lim(int'(m_rf[WX][10:0]) + op.dx, X_MAX);
    ny = lim(int'(m_rf[WY][10:0]) - op.dy, Y_MAX);
    push_exp(1'b0, ADDR_X, 32'(nx), 1'b0);
    push_exp(1'b0, ADDR_Y, 32'(ny), 1'b1);
    m_rf[WX] = 32'(nx);
    m_rf[WY] = 32'(ny);
    m_prio_mv = 1'b0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic check_out(bit is_ack, logic [11:0] a, logic [31:0] d);
    exp_t e;
    bit ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output ack=%0d addr=%h data=%h cyc=%0d", is_ack, a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    ok = (e.ack == is_ack) && (is_ack || e.addr == a) && (e.data == d) &&
         (!e.b2b || cyc == last_wr + 1);
    if (!ok) begin
      errors++;
      $display("FAIL scoreboard got ack=%0d addr=%h data=%h cyc=%0d exp ack=%0d addr=%h data=%h b2b=%0d last_wr=%0d",
               is_ack, a, d, cyc, e.ack, e.addr, e.data, e.b2b, last_wr);
    end
    if (!is_ack) last_wr = cyc;
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (bus.rf_we)   check_out(1'b0, bus.rf_addr, bus.rf_wd);
    if (bus.cpu_ack) check_out(1'b1, 12'h0, bus.cpu_rd);
  end

  task automatic cpu_burst(input bit chk_lat);
    cop_t op;
    bit   got;
    int   t0;
    while (cpu_q.size() > 0) begin
      op = cpu_q.pop_front();
      bus.cpu_req = 1'b1; bus.cpu_we = op.we; bus.cpu_addr = op.addr; bus.cpu_wd = op.wd;
      t0 = cyc;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        got = bus.cpu_ack;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL cpu_ack_timeout addr=%h", op.addr);
      end else if (chk_lat) begin
        chk("cpu_ack_latency", 32'(cyc - t0), 32'd2);
      end
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic mv_burst(input bit seq);
    mop_t op;
    bit   got;
    while (mv_q.size() > 0) begin
      op = mv_q.pop_front();
      bus.mv_valid = 1'b1; bus.mv_dx = 9'(op.dx); bus.mv_dy = 9'(op.dy);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        got = bus.mv_ready;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL mv_ready_timeout dx=%0d dy=%0d", op.dx, op.dy);
      end
      @(posedge clk); #1;
      if (seq) begin
        @(negedge clk);
        chk("mv_ready_single_cycle", 32'(bus.mv_ready), 32'd0);
        @(posedge clk); #1;
        bus.mv_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.mv_valid = 1'b0;
  endtask

  task automatic seq_cpu(bit we, logic [11:0] a, logic [31:0] d);
    cop_t op;
    op.we = we; op.addr = a; op.wd = d;
    model_cpu(op);
    cpu_q.push_back(op);
    cpu_burst(1'b1);
  endtask

  task automatic seq_mv(int dx, int dy);
    mop_t op;
    op.dx = dx; op.dy = dy;
    model_mv(op);
    mv_q.push_back(op);
    mv_burst(1'b1);
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_mv_ready"}, 32'(bus.mv_ready), 32'd0);
    chk({tag, "_rf_we"},    32'(bus.rf_we),    32'd0);
    chk({tag, "_rf_addr"},  32'(bus.rf_addr),  32'd0);
    chk({tag, "_rf_wd"},    bus.rf_wd,         32'd0);
    chk({tag, "_cpu_ack"},  32'(bus.cpu_ack),  32'd0);
    chk({tag, "_cpu_rd"},   bus.cpu_rd,        32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_prio_mv = 1'b0;
  endtask

  initial begin
    cop_t c;
    mop_t m;
    bit   got;
    int   nc, nm, w, r;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wd = '0;
    bus.mv_valid = 1'b1; bus.mv_dx = '0; bus.mv_dy = '0;
    for (int i = 0; i < 4; i++) m_rf[i] = 32'h0;
    m_prio_mv = 1'b0;

    // Reset state, with a pending motion packet that must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    bus.mv_valid = 1'b0;
    @(posedge clk); #1;
    rf_clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    seq_cpu(1'b1, ADDR_X, 32'd100);
    seq_cpu(1'b0, ADDR_X, 32'h0);
    seq_cpu(1'b1, ADDR_Y, 32'd50);
    seq_mv(10, 5);
    seq_cpu(1'b1, ADDR_X, 32'd5);
    seq_cpu(1'b1, ADDR_Y, 32'd470);
    seq_mv(-20, -20);
    seq_cpu(1'b1, ADDR_X, 32'd630);
    seq_mv(20, 0);
    seq_mv(0, 0);
    seq_cpu(1'b1, ADDR_X, 32'hFFFF_F800 | 32'd300);
    seq_mv(-256, 255);
    seq_cpu(1'b1, ADDR_Y, 32'd479);
    seq_mv(0, -1);
    seq_cpu(1'b1, 12'h00C, 32'hDEAD_BEEF);
    seq_cpu(1'b0, 12'h00C, 32'h0);
    seq_cpu(1'b0, ADDR_Y, 32'h0);

    // Reset while the X write is on the bus: packet dropped, nothing written
    bus.mv_valid = 1'b1; bus.mv_dx = 9'd7; bus.mv_dy = 9'd7;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.mv_ready;
    end
    chk("midrst_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mv_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_prio_mv = 1'b0;
    @(posedge clk); #1;
    seq_mv(3, -3);
    seq_cpu(1'b0, ADDR_X, 32'h0);

    // Both sources held from reset: grants alternate, CPU first
    pulse_reset();
    nc = 4; nm = 4;
    for (int i = 0; i < nc; i++) begin
      c.we = 1'($urandom_range(1)); c.addr = 12'($urandom_range(3) * 4); c.wd = 32'($urandom_range(400));
      cpu_q.push_back(c);
    end
    for (int i = 0; i < nm; i++) begin
      m.dx = int'($urandom_range(511)) - 256; m.dy = int'($urandom_range(511)) - 256;
      mv_q.push_back(m);
    end
    begin
      int ic, im;
      ic = 0; im = 0;
      while (ic < nc || im < nm) begin
        if (ic < nc && (im >= nm || !m_prio_mv)) begin model_cpu(cpu_q[ic]); ic++; end
        else begin model_mv(mv_q[im]); im++; end
      end
    end
    fork
      cpu_burst(1'b0);
      mv_burst(1'b0);
    join
    repeat (3) @(posedge clk);
    #1;

    // Random sequential traffic
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(2))
        0: begin
          w = int'($urandom_range(3));
          r = int'($urandom());
          if (w == WX)      seq_cpu(1'b1, 12'(w * 4), {r[31:11], 11'($urandom_range(X_MAX))});
          else if (w == WY) seq_cpu(1'b1, 12'(w * 4), {r[31:11], 11'($urandom_range(Y_MAX))});
          else              seq_cpu(1'b1, 12'(w * 4), 32'(r));
        end
        1: seq_cpu(1'b0, 12'($urandom_range(3) * 4), 32'h0);
        default: seq_mv(int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
